// File: rtl/shift_pkg.sv
// Shared types and sizing for the shift sequencer slice.
// FSM state encoding and default data/amount widths live here.
package shift_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_AMT_W = 4;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/shift_count.sv
// Loadable down-counter that tracks the remaining shift cycles.
// Saturates at zero; o_is_one marks the final shift cycle.
module shift_count
    import shift_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_is_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_is_one = (r_count == W'(1));

endmodule

// File: rtl/shifter8bit.sv
// 8-bit load/shift register driven by the sequencer.
// ASR fill comes from LoadVal[7], so LoadVal must be held while shifting.
module shifter8bit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] LoadVal,
    input  logic       Load_n,
    input  logic       ShiftRight,
    input  logic       ASR,
    output logic [7:0] Q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (!Load_n) begin
            Q <= LoadVal;
        end else if (ShiftRight) begin
            Q <= {ASR & LoadVal[7], Q[7:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller: load, shift `amount` times, capture, return.
// Moore FSM; every shifter control is decoded from the state register.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic             cmd_arith,
    output logic [WIDTH-1:0] sh_load_val,
    output logic             sh_load_n,
    output logic             sh_shift,
    output logic             sh_asr,
    input  logic [WIDTH-1:0] sh_q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_res_data;
    logic             r_arith;
    logic [CW-1:0]    r_amt;
    logic [CW-1:0]    w_amt_clamp;
    logic             w_accept;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_one;

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_amt_clamp = (32'(cmd_amount) > 32'(WIDTH))
                       ? CW'(WIDTH)
                       : CW'(cmd_amount);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_arith <= 1'b0;
            r_amt   <= '0;
        end else if (w_accept) begin
            r_value <= cmd_value;
            r_arith <= cmd_arith;
            r_amt   <= w_amt_clamp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_data <= '0;
        end else if (r_state == CAPTURE) begin
            r_res_data <= sh_q;
        end
    end

    // Counter is primed during LOAD so it holds `amount` on SHIFT entry.
    assign w_cnt_load = (r_state == LOAD);
    assign w_cnt_dec  = (r_state == SHIFT);

    shift_count #(
        .W (CW)
    ) u_count (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (r_amt),
        .i_dec      (w_cnt_dec),
        .o_is_one   (w_cnt_one)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_next = LOAD;
            LOAD:    w_next = (r_amt != '0) ? SHIFT : CAPTURE;
            SHIFT:   if (w_cnt_one) w_next = CAPTURE;
            CAPTURE: w_next = DONE;
            DONE:    if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        sh_load_n   = 1'b1;
        sh_shift    = 1'b0;
        sh_asr      = 1'b0;
        sh_load_val = r_value;
        res_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready   = !reset;
                sh_load_val = '0;
            end
            LOAD: begin
                sh_load_n = 1'b0;
                sh_asr    = r_arith;
            end
            SHIFT: begin
                sh_shift = 1'b1;
                sh_asr   = r_arith;
            end
            CAPTURE: begin
                sh_asr = r_arith;
            end
            DONE: begin
                res_valid = 1'b1;
            end
            default: begin
                sh_load_val = '0;
            end
        endcase
    end

    assign res_data = r_res_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer driving a real shifter8bit neighbour.
// Table vectors, hand sequences and random commands vs a reference model.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_value;
    logic [3:0] cmd_amount;
    logic       cmd_arith;
    logic [7:0] sh_load_val;
    logic       sh_load_n;
    logic       sh_shift;
    logic       sh_asr;
    logic [7:0] sh_q;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_value   (cmd_value),
        .cmd_amount  (cmd_amount),
        .cmd_arith   (cmd_arith),
        .sh_load_val (sh_load_val),
        .sh_load_n   (sh_load_n),
        .sh_shift    (sh_shift),
        .sh_asr      (sh_asr),
        .sh_q        (sh_q),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data)
    );

    shifter8bit u_sh (
        .clk        (clk),
        .reset_n    (~reset),
        .LoadVal    (sh_load_val),
        .Load_n     (sh_load_n),
        .ShiftRight (sh_shift),
        .ASR        (sh_asr),
        .Q          (sh_q)
    );

    typedef struct {
        logic [7:0] v;
        logic [3:0] a;
        logic       ar;
        int         hold;
        bit         poke;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] v, input int a,
                                         input logic ar);
        int n;
        int r;
        n = (a > 8) ? 8 : a;
        if (ar) r = int'($signed(v)) >>> n;
        else    r = int'(v) >> n;
        return r[7:0];
    endfunction

    task automatic run_cmd(input logic [7:0] v, input logic [3:0] a,
                           input logic ar, input int hold, input bit poke,
                           input logic [7:0] exp_d, input string tag);
        int amt;
        int n;
        int loads;
        int shifts;
        int bad_sh;
        int bad_hold;
        int wc;
        logic [7:0] held;
        amt = (a > 4'd8) ? 8 : int'(a);
        loads = 0;
        shifts = 0;
        bad_sh = 0;
        bad_hold = 0;
        wc = 0;
        @(negedge clk);
        cmd_value  = v;
        cmd_amount = a;
        cmd_arith  = ar;
        cmd_valid  = 1'b1;
        res_ready  = (hold == 0);
        while (!cmd_ready && wc < 20) begin
            @(negedge clk);
            wc++;
        end
        if (!cmd_ready) begin
            chk({tag, "_accept_timeout"}, 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 40) begin
            if (!sh_load_n) loads++;
            if (sh_shift) begin
                shifts++;
                if (sh_asr !== ar || sh_load_val !== v) bad_sh++;
            end
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, amt + 2);
        chk({tag, "_loads"}, loads, 1);
        chk({tag, "_shifts"}, shifts, amt);
        chk({tag, "_shift_ctl"}, bad_sh, 0);
        chk({tag, "_data"}, res_data, exp_d);
        if (!res_valid) return;
        held = res_data;
        if (poke) begin
            cmd_value = ~v;
            cmd_amount = 4'd1;
            cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid || res_data !== held || cmd_ready || !sh_load_n)
                bad_hold++;
        end
        if (hold > 0) chk({tag, "_hold"}, bad_hold, 0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_release"}, {res_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int shifts;
        logic [7:0] rv;
        logic [3:0] ra;
        logic       rar;
        tbl[0] = '{8'h96, 4'd2,  1'b0, 0, 1'b0, 8'h25};
        tbl[1] = '{8'h96, 4'd2,  1'b1, 0, 1'b0, 8'hE5};
        tbl[2] = '{8'h96, 4'd0,  1'b0, 0, 1'b0, 8'h96};
        tbl[3] = '{8'h80, 4'd12, 1'b1, 0, 1'b0, 8'hFF};
        tbl[4] = '{8'h80, 4'd12, 1'b0, 0, 1'b0, 8'h00};
        tbl[5] = '{8'h7F, 4'd8,  1'b1, 0, 1'b0, 8'h00};
        tbl[6] = '{8'hC3, 4'd1,  1'b1, 0, 1'b0, 8'hE1};
        tbl[7] = '{8'h3C, 4'd1,  1'b0, 5, 1'b1, 8'h1E};
        tbl[8] = '{8'hFF, 4'd15, 1'b1, 2, 1'b0, 8'hFF};

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_value = '0;
        cmd_amount = '0;
        cmd_arith = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ctl", {sh_load_n, sh_shift, sh_asr}, 3'b100);
        chk("rst_load_val", sh_load_val, 0);
        chk("rst_res", {res_valid, res_data}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 9; i++)
            run_cmd(tbl[i].v, tbl[i].a, tbl[i].ar, tbl[i].hold,
                    tbl[i].poke, tbl[i].exp, $sformatf("vec%0d", i));

        // Reset arrives during the second SHIFT cycle of a 6-shift command.
        @(negedge clk);
        cmd_value = 8'h96;
        cmd_amount = 4'd6;
        cmd_arith = 1'b1;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        shifts = 0;
        n = 0;
        while (n < 20) begin
            if (sh_shift) shifts++;
            if (shifts == 2) break;
            @(negedge clk);
            n++;
        end
        chk("midrst_reach_shift2", shifts, 2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {res_valid, sh_shift, cmd_ready, sh_load_n},
            4'b0001);
        @(negedge clk);
        chk("midrst_held_ready", cmd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", cmd_ready, 1);
        run_cmd(8'h5A, 4'd3, 1'b0, 0, 1'b0, 8'h0B, "post_rst");

        for (int i = 0; i < 30; i++) begin
            rv  = 8'($urandom_range(0, 255));
            ra  = 4'($urandom_range(0, 15));
            rar = 1'($urandom_range(0, 1));
            run_cmd(rv, ra, rar, $urandom_range(0, 2), 1'b0,
                    model(rv, int'(ra), rar), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
